// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path: state encoding,
// opcodes, ALU operation classes and datapath mux-select codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational output decode for the multicycle controller: maps the current
// state (plus the few qualifying inputs) onto datapath selects and strobes.
module ctrl_outdec
  import riscv_pkg::*;
(
  input  state_t     state_i,
  input  logic [6:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  input  logic       reset_i,
  output logic [1:0] alu_op_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       illegal_o
);

  logic pc_update;
  logic branch;
  logic ir_write_raw;
  logic reg_write_raw;
  logic mem_write_raw;
  logic illegal_raw;

  always_comb begin
    alu_op_o      = ALU_ADD;
    alu_src_a_o   = SRCA_PC;
    alu_src_b_o   = SRCB_RD2;
    result_src_o  = RES_ALUOUT;
    adr_src_o     = ADR_PC;
    ir_write_raw  = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    case (state_i)
      S_FETCH: begin
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURESULT;
        ir_write_raw = mem_ready_i;
        pc_update    = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        illegal_raw = !is_supported_op(op_i);
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_RD1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src_o = ADR_RESULT;
      end
      S_MEMWB: begin
        result_src_o  = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o     = ADR_RESULT;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_o = SRCA_RD1;
        alu_op_o    = ALU_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a_o = SRCA_RD1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_o = SRCA_RD1;
        alu_op_o    = ALU_SUB;
        branch      = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked during reset; the state register is already FETCH so
  // the selects naturally show their FETCH values.
  assign ir_write_o  = ir_write_raw & ~reset_i;
  assign pc_write_o  = (pc_update | (branch & zero_i)) & ~reset_i;
  assign reg_write_o = reg_write_raw & ~reset_i;
  assign mem_write_o = mem_write_raw & ~reset_i;
  assign illegal_o   = illegal_raw & ~reset_i;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: state register and next-state logic,
// with the output decode delegated to ctrl_outdec.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

  ctrl_outdec u_outdec (
    .state_i      (state_q),
    .op_i         (op),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .reset_i      (reset),
    .alu_op_o     (alu_op),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .result_src_o (result_src),
    .adr_src_o    (adr_src),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .reg_write_o  (reg_write),
    .mem_write_o  (mem_write),
    .illegal_o    (illegal)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: walks each instruction
// class through its state sequence and checks selects and strobes per cycle.
module tb_multicycle_ctrl;

  localparam logic [3:0] F   = 4'd0;
  localparam logic [3:0] D   = 4'd1;
  localparam logic [3:0] MA  = 4'd2;
  localparam logic [3:0] MR  = 4'd3;
  localparam logic [3:0] MWB = 4'd4;
  localparam logic [3:0] MW  = 4'd5;
  localparam logic [3:0] ER  = 4'd6;
  localparam logic [3:0] EI  = 4'd7;
  localparam logic [3:0] AWB = 4'd8;
  localparam logic [3:0] BQ  = 4'd9;
  localparam logic [3:0] JL  = 4'd10;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    tests++; if (state !== F) begin fails++; $display("FAIL reset_async_state got %0d want %0d", state, F); end
    tests++; if ({ir_write, pc_write, reg_write, mem_write, illegal} !== 5'b0) begin
      fails++; $display("FAIL reset_strobes got %b want 00000", {ir_write, pc_write, reg_write, mem_write, illegal}); end
    tests++; if ({alu_src_a, alu_src_b, alu_op, result_src, adr_src} !== 9'b00_10_00_10_0) begin
      fails++; $display("FAIL reset_selects got %b want 001000100", {alu_src_a, alu_src_b, alu_op, result_src, adr_src}); end
    step();
    tests++; if (state !== F || ir_write !== 1'b0 || pc_write !== 1'b0) begin
      fails++; $display("FAIL reset_held state=%0d ir=%b pc=%b want 0 0 0", state, ir_write, pc_write); end
    reset = 1'b0;
    #1;
    tests++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
      fails++; $display("FAIL fetch_after_reset ir=%b pc=%b want 1 1", ir_write, pc_write); end
    $display("[TB] reset: done");
  endtask

  task automatic test_fetch_stall;
    mem_ready = 1'b0;
    #1;
    tests++; if (ir_write !== 1'b0 || pc_write !== 1'b0) begin
      fails++; $display("FAIL fetch_stall_strobes ir=%b pc=%b want 0 0", ir_write, pc_write); end
    step();
    tests++; if (state !== F) begin fails++; $display("FAIL fetch_stall_state got %0d want %0d", state, F); end
    mem_ready = 1'b1;
    #1;
    $display("[TB] fetch stall: done");
  endtask

  task automatic test_rtype;
    logic [3:0] exp_s [5] = '{F, D, ER, AWB, F};
    op = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      tests++; if (state !== exp_s[i]) begin fails++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, state, exp_s[i]); end
      tests++; if (reg_write !== (exp_s[i] == AWB)) begin fails++; $display("FAIL rtype_regwrite[%0d] got %b want %b", i, reg_write, exp_s[i] == AWB); end
      if (exp_s[i] == ER) begin
        tests++; if ({alu_op, alu_src_a, alu_src_b} !== 6'b10_10_00) begin
          fails++; $display("FAIL rtype_exec_ctrl got %b want 101000", {alu_op, alu_src_a, alu_src_b}); end
      end
      if (exp_s[i] == D) begin
        tests++; if ({alu_src_a, alu_src_b, illegal} !== 5'b01_01_0) begin
          fails++; $display("FAIL decode_ctrl got %b want 01010", {alu_src_a, alu_src_b, illegal}); end
      end
    end
    $display("[TB] rtype: done");
  endtask

  task automatic test_itype;
    op = 7'b0010011;
    step();
    step();
    tests++; if (state !== EI || {alu_op, alu_src_a, alu_src_b} !== 6'b10_10_01) begin
      fails++; $display("FAIL itype_exec state=%0d ctrl=%b want 7 101001", state, {alu_op, alu_src_a, alu_src_b}); end
    step();
    tests++; if (state !== AWB || reg_write !== 1'b1 || result_src !== 2'b00) begin
      fails++; $display("FAIL itype_wb state=%0d rw=%b rs=%b want 8 1 00", state, reg_write, result_src); end
    step();
    tests++; if (state !== F) begin fails++; $display("FAIL itype_end got %0d want %0d", state, F); end
    $display("[TB] itype: done");
  endtask

  task automatic test_lw_wait;
    op = 7'b0000011;
    step();
    step();
    tests++; if (state !== MA || {alu_src_a, alu_src_b, alu_op} !== 6'b10_01_00) begin
      fails++; $display("FAIL lw_memadr state=%0d ctrl=%b want 2 100100", state, {alu_src_a, alu_src_b, alu_op}); end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (state !== MR || adr_src !== 1'b1 || result_src !== 2'b00 || reg_write !== 1'b0) begin
        fails++; $display("FAIL lw_memread[%0d] state=%0d adr=%b rs=%b rw=%b want 3 1 00 0", i, state, adr_src, result_src, reg_write); end
      if (i == 3) mem_ready = 1'b1;
    end
    step();
    tests++; if (state !== MWB || result_src !== 2'b01 || reg_write !== 1'b1) begin
      fails++; $display("FAIL lw_memwb state=%0d rs=%b rw=%b want 4 01 1", state, result_src, reg_write); end
    step();
    tests++; if (state !== F) begin fails++; $display("FAIL lw_end got %0d want %0d", state, F); end
    $display("[TB] lw with wait: done");
  endtask

  task automatic test_beq;
    logic zvals [2] = '{1'b1, 1'b0};
    op = 7'b1100011;
    for (int k = 0; k < 2; k++) begin
      zero = zvals[k];
      step();
      tests++; if (state !== D || pc_write !== 1'b0) begin
        fails++; $display("FAIL beq_decode[%0d] state=%0d pcw=%b want 1 0", k, state, pc_write); end
      step();
      tests++; if (state !== BQ || alu_op !== 2'b01 || pc_write !== zvals[k]) begin
        fails++; $display("FAIL beq_exec[%0d] state=%0d aluop=%b pcw=%b want 9 01 %b", k, state, alu_op, pc_write, zvals[k]); end
      step();
      tests++; if (state !== F) begin fails++; $display("FAIL beq_end[%0d] got %0d want %0d", k, state, F); end
    end
    zero = 1'b0;
    $display("[TB] beq taken/not taken: done");
  endtask

  task automatic test_illegal;
    op = 7'b1111111;
    step();
    tests++; if (state !== D || illegal !== 1'b1) begin
      fails++; $display("FAIL illegal_decode state=%0d illegal=%b want 1 1", state, illegal); end
    tests++; if ({ir_write, pc_write, reg_write, mem_write} !== 4'b0) begin
      fails++; $display("FAIL illegal_strobes got %b want 0000", {ir_write, pc_write, reg_write, mem_write}); end
    step();
    tests++; if (state !== F || illegal !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      fails++; $display("FAIL illegal_after state=%0d illegal=%b rw=%b mw=%b want 0 0 0 0", state, illegal, reg_write, mem_write); end
    $display("[TB] illegal opcode: done");
  endtask

  task automatic test_sw_reset;
    op = 7'b0100011;
    step();
    step();
    mem_ready = 1'b0;
    step();
    tests++; if (state !== MW || mem_write !== 1'b1 || adr_src !== 1'b1) begin
      fails++; $display("FAIL sw_memwrite state=%0d mw=%b adr=%b want 5 1 1", state, mem_write, adr_src); end
    step();
    tests++; if (state !== MW || mem_write !== 1'b1) begin
      fails++; $display("FAIL sw_memwrite_hold state=%0d mw=%b want 5 1", state, mem_write); end
    #2 reset = 1'b1;
    #1;
    tests++; if (state !== F || mem_write !== 1'b0) begin
      fails++; $display("FAIL sw_midreset state=%0d mw=%b want 0 0", state, mem_write); end
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    tests++; if (state !== F || ir_write !== 1'b1) begin
      fails++; $display("FAIL sw_post_reset state=%0d ir=%b want 0 1", state, ir_write); end
    step();
    step();
    step();
    tests++; if (state !== MW || mem_write !== 1'b1) begin
      fails++; $display("FAIL sw_rerun state=%0d mw=%b want 5 1", state, mem_write); end
    step();
    tests++; if (state !== F) begin fails++; $display("FAIL sw_end got %0d want %0d", state, F); end
    $display("[TB] sw with mid-write reset: done");
  endtask

  task automatic test_jal;
    op = 7'b1101111;
    step();
    step();
    tests++; if (state !== JL || pc_write !== 1'b1 || reg_write !== 1'b0) begin
      fails++; $display("FAIL jal_state state=%0d pcw=%b rw=%b want 10 1 0", state, pc_write, reg_write); end
    tests++; if ({alu_src_a, alu_src_b, alu_op, result_src} !== 8'b01_10_00_00) begin
      fails++; $display("FAIL jal_selects got %b want 01100000", {alu_src_a, alu_src_b, alu_op, result_src}); end
    step();
    tests++; if (state !== AWB || reg_write !== 1'b1 || pc_write !== 1'b0) begin
      fails++; $display("FAIL jal_wb state=%0d rw=%b pcw=%b want 8 1 0", state, reg_write, pc_write); end
    step();
    tests++; if (state !== F) begin fails++; $display("FAIL jal_end got %0d want %0d", state, F); end
    $display("[TB] jal: done");
  endtask

  initial begin
    reset = 1'b0; op = 7'b0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    test_reset();
    test_fetch_stall();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_sw_reset();
    test_jal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
